// File: rtl/cache_assoc.sv
// cache_assoc: write-back, write-allocate, set-associative cache (1 or 2 ways)
// between the word-addressed core port and a 128-bit block memory port.
// A miss costs one COMPARE cycle, an optional WRITEBACK of a dirty victim and
// one ALLOCATE. The request then completes as a hit on the next COMPARE cycle.
//
// Ports:
//   clk         rising-edge clock
//   proc_reset  synchronous active-high reset
//   proc_read   core read request
//   proc_write  core write request (wins when both are high)
//   proc_addr   word address {tag, index, word offset}
//   proc_wdata  core write data
//   proc_rdata  read data, valid while proc_stall is low
//   proc_stall  request not yet complete
//   mem_read    block fill request
//   mem_write   block write-back request
//   mem_addr    block address (byte address [31:4])
//   mem_wdata   victim block being written back
//   mem_rdata   fill block from memory
//   mem_ready   one-cycle completion pulse from memory
//   hit_cnt     saturating count of completed hits
//   miss_cnt    saturating count of misses
module cache_assoc #(
    parameter int WAYS  = 2,
    parameter int SETS  = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             proc_reset,
    input  logic             proc_read,
    input  logic             proc_write,
    input  logic [29:0]      proc_addr,
    input  logic [31:0]      proc_wdata,
    output logic [31:0]      proc_rdata,
    output logic             proc_stall,
    output logic             mem_read,
    output logic             mem_write,
    output logic [27:0]      mem_addr,
    output logic [127:0]     mem_wdata,
    input  logic [127:0]     mem_rdata,
    input  logic             mem_ready,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);
    localparam int IB = $clog2(SETS);
    localparam int TW = 28 - IB;

    typedef enum logic [1:0] {COMPARE, WRITEBACK, ALLOCATE} state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t          state;
    logic [SETS-1:0] valid [WAYS];
    logic [SETS-1:0] dirty [WAYS];
    logic [TW-1:0]   tags  [WAYS][SETS];
    logic [127:0]    lines [WAYS][SETS];
    logic            vict_q;

    logic [IB-1:0]   idx;
    logic [TW-1:0]   tg;
    logic [1:0]      off;
    logic            req;
    logic            hit;
    logic            hit_way;
    logic            vict;
    logic            lru_way;

    assign idx = proc_addr[IB+1:2];
    assign tg  = proc_addr[29:IB+2];
    assign off = proc_addr[1:0];
    assign req = proc_read | proc_write;

    always_comb begin
        hit     = 1'b0;
        hit_way = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[w][idx] && tags[w][idx] == tg) begin
                hit     = 1'b1;
                hit_way = w[0];
            end
        end
    end

    // Victim: first invalid way (way 0 first), otherwise the LRU way.
    always_comb begin
        vict = 1'b0;
        if (WAYS == 2) begin
            if (!valid[0][idx])
                vict = 1'b0;
            else if (!valid[WAYS-1][idx])
                vict = 1'b1;
            else
                vict = lru_way;
        end
    end

    // One LRU bit per set, pointing at the least-recently-used way.
    generate
        if (WAYS == 2) begin : g_lru
            logic [SETS-1:0] lru;
            always_ff @(posedge clk) begin
                if (proc_reset)
                    lru <= '0;
                else if (state == COMPARE && req && hit)
                    lru[idx] <= ~hit_way;
            end
            assign lru_way = lru[idx];
        end else begin : g_no_lru
            assign lru_way = 1'b0;
        end
    endgenerate

    assign proc_stall = (state != COMPARE) || (req && !hit);
    assign proc_rdata = lines[hit_way][idx][{off, 5'b00000} +: 32];
    assign mem_wdata  = lines[vict_q][idx];
    assign mem_addr   = (state == WRITEBACK) ? {tags[vict_q][idx], idx} : proc_addr[29:2];

    // Control FSM: state, line status, counters and memory strobes.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state     <= COMPARE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
            for (int w = 0; w < WAYS; w++) begin
                valid[w] <= '0;
                dirty[w] <= '0;
            end
        end else begin
            case (state)
                COMPARE: begin
                    if (req) begin
                        if (hit) begin
                            hit_cnt <= sat_inc(hit_cnt);
                            if (proc_write)
                                dirty[hit_way][idx] <= 1'b1;
                        end else begin
                            miss_cnt <= sat_inc(miss_cnt);
                            vict_q   <= vict;
                            if (valid[vict][idx] && dirty[vict][idx]) begin
                                state     <= WRITEBACK;
                                mem_write <= 1'b1;
                            end else begin
                                state    <= ALLOCATE;
                                mem_read <= 1'b1;
                            end
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ready) begin
                        state     <= ALLOCATE;
                        mem_write <= 1'b0;
                        mem_read  <= 1'b1;
                    end
                end
                ALLOCATE: begin
                    if (mem_ready) begin
                        state                <= COMPARE;
                        mem_read             <= 1'b0;
                        valid[vict_q][idx]   <= 1'b1;
                        dirty[vict_q][idx]   <= 1'b0;
                    end
                end
                default: state <= COMPARE;
            endcase
        end
    end

    // Line storage: word writes on a write hit, whole-block fills on allocate.
    always_ff @(posedge clk) begin
        if (state == COMPARE && req && hit && proc_write)
            lines[hit_way][idx][{off, 5'b00000} +: 32] <= proc_wdata;
        if (state == ALLOCATE && mem_ready) begin
            lines[vict_q][idx] <= mem_rdata;
            tags[vict_q][idx]  <= tg;
        end
    end

endmodule
